// File: rtl/tower_grid_pkg.sv
// Shared widths, types and helpers for the tower grid accumulator.
// Widths here are the defaults; the top module overrides them through its parameters.
package tower_grid_pkg;

    localparam int ETA_BITS_DEF = 5;
    localparam int PHI_BITS_DEF = 5;
    localparam int ET_W_DEF     = 11;
    localparam int E_W_DEF      = 11;
    localparam int CNT_W_DEF    = 16;

    typedef struct packed {
        logic [ET_W_DEF-1:0] et;
        logic [E_W_DEF-1:0]  e;
    } cell_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic [31:0] pack_addr(input logic [15:0] phi, input logic [15:0] eta,
                                              input int unsigned eta_bits);
        return ({16'b0, phi} << eta_bits) | {16'b0, eta};
    endfunction

    // Operands must fit in w bits. Bit w of the result flags overflow; bits [w-1:0] hold the clamped sum.
    function automatic logic [32:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] lim;
        logic [32:0] sum;
        lim = (33'd1 << w) - 33'd1;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > lim) ? ((33'd1 << w) | lim) : sum;
    endfunction

endpackage

// File: rtl/tower_grid_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, read returns the old word on collision.
module tower_grid_ram #(
    parameter int AW = 10,
    parameter int DW = 22
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [1 << AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        q <= mem[raddr];
    end

endmodule

// File: rtl/tower_grid_accum.sv
// Eta x phi grid of saturating et/e accumulators with a 2-stage write pipeline,
// a 1-cycle read port and a hardware clear sweep.
//   state | meaning
//   CLEAR | sweeping zeros through the grid, one cell per cycle; writes and reads refused
//   RUN   | accepting writes and reads
module tower_grid_accum
    import tower_grid_pkg::*;
#(
    parameter int ETA_BITS = ETA_BITS_DEF,
    parameter int PHI_BITS = PHI_BITS_DEF,
    parameter int ET_W     = ET_W_DEF,
    parameter int E_W      = E_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_start,
    output logic                busy,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [ETA_BITS-1:0] wr_eta,
    input  logic [PHI_BITS-1:0] wr_phi,
    input  logic [ET_W-1:0]     wr_et,
    input  logic [E_W-1:0]      wr_e,
    input  logic                rd_valid,
    input  logic [ETA_BITS-1:0] rd_eta,
    input  logic [PHI_BITS-1:0] rd_phi,
    output logic                rd_data_valid,
    output logic [ET_W-1:0]     rd_et,
    output logic [E_W-1:0]      rd_e,
    output logic [CNT_W-1:0]    hit_count,
    output logic                sat_flag
);

    localparam int AW  = ETA_BITS + PHI_BITS;
    localparam int DW  = ET_W + E_W;
    localparam int ETX = ET_W + 1;
    localparam int EX  = E_W + 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   sweep_addr;
    logic            run, accept;
    logic [AW-1:0]   wr_addr, rd_addr;

    logic            s1_valid, s2_valid, s3_valid;
    logic [AW-1:0]   s1_addr, s2_addr, s3_addr;
    logic [ET_W-1:0] s1_et;
    logic [E_W-1:0]  s1_e;
    logic [DW-1:0]   s2_data, s3_data;
    logic [DW-1:0]   old_word, s1_data;
    logic [ETX-1:0]  et_res;
    logic [EX-1:0]   e_res;
    logic            s1_sat;

    logic            ram_we;
    logic [AW-1:0]   ram_waddr;
    logic [DW-1:0]   ram_wdata, qa, qb;

    logic            rd_hit, r1_valid, r1_hit;
    logic [DW-1:0]   rd_fwd, r1_data, rd_sel, rd_hold, rd_word;

    assign run     = (state == RUN);
    assign accept  = wr_valid && wr_ready;
    assign wr_addr = AW'(pack_addr(16'(wr_phi), 16'(wr_eta), ETA_BITS));
    assign rd_addr = AW'(pack_addr(16'(rd_phi), 16'(rd_eta), ETA_BITS));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLEAR;
            sweep_addr <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) begin
                sweep_addr <= sweep_addr + AW'(1);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (sweep_addr == '1) state_nxt = RUN;
            RUN:     if (clear_start) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        busy     = (state == CLEAR);
        wr_ready = (state == RUN);
    end

    // Both the write pipeline and the read port need a lookup every cycle, so the grid is mirrored.
    tower_grid_ram #(.AW(AW), .DW(DW)) u_ram_wr (
        .clk(clk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata), .raddr(wr_addr), .q(qa)
    );
    tower_grid_ram #(.AW(AW), .DW(DW)) u_ram_rd (
        .clk(clk), .we(ram_we), .waddr(ram_waddr), .wdata(ram_wdata), .raddr(rd_addr), .q(qb)
    );

    // In-flight writes are dropped once the sweep starts; the sweep would erase them anyway.
    assign ram_we    = !run || s2_valid;
    assign ram_waddr = run ? s2_addr : sweep_addr;
    assign ram_wdata = run ? s2_data : '0;

    // s3 covers the word committed on the same edge the RAM was read, which the RAM returns stale.
    always_comb begin
        old_word = qa;
        if (s3_valid && s3_addr == s1_addr) old_word = s3_data;
        if (s2_valid && s2_addr == s1_addr) old_word = s2_data;
    end

    assign et_res  = ETX'(sat_add(32'(old_word[DW-1:E_W]), 32'(s1_et), ET_W));
    assign e_res   = EX'(sat_add(32'(old_word[E_W-1:0]), 32'(s1_e), E_W));
    assign s1_data = {et_res[ET_W-1:0], e_res[E_W-1:0]};
    assign s1_sat  = et_res[ET_W] || e_res[E_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s3_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid && run;
            s3_valid <= s2_valid && run;
        end
    end

    always_ff @(posedge clk) begin
        s1_addr <= wr_addr;
        s1_et   <= wr_et;
        s1_e    <= wr_e;
        s2_addr <= s1_addr;
        s2_data <= s1_data;
        s3_addr <= s2_addr;
        s3_data <= s2_data;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_count <= '0;
            sat_flag  <= 1'b0;
        end else if (run && clear_start) begin
            hit_count <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (accept && hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            if (s1_valid && run && s1_sat) sat_flag <= 1'b1;
        end
    end

    always_comb begin
        rd_hit = 1'b0;
        rd_fwd = s2_data;
        if (s1_valid && s1_addr == rd_addr) begin
            rd_hit = 1'b1;
            rd_fwd = s1_data;
        end else if (s2_valid && s2_addr == rd_addr) begin
            rd_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r1_valid <= 1'b0;
            r1_hit   <= 1'b0;
            rd_hold  <= '0;
        end else begin
            r1_valid <= rd_valid && run;
            r1_hit   <= rd_hit;
            if (r1_valid) rd_hold <= rd_sel;
        end
    end

    always_ff @(posedge clk) begin
        r1_data <= rd_fwd;
    end

    assign rd_sel        = r1_hit ? r1_data : qb;
    assign rd_word       = r1_valid ? rd_sel : rd_hold;
    assign rd_data_valid = r1_valid;
    assign rd_et         = rd_word[DW-1:E_W];
    assign rd_e          = rd_word[E_W-1:0];

endmodule
